// File: rtl/mq_pkg.sv
// Shared types and constants for the MQ coder code-register stage.
// FSM encoding, register widths and byte-out masks.
package mq_pkg;

    localparam int          C_W     = 28;
    localparam logic [3:0]  CT_INIT = 4'd12;
    localparam logic [27:0] MASK20  = 28'h00FFFFF;
    localparam logic [27:0] MASK19  = 28'h007FFFF;
    localparam logic [7:0]  STUFF   = 8'hFF;

    typedef enum logic [2:0] {
        RUN,
        SHIFT,
        FL_SET,
        FL_SH1,
        FL_SH2,
        FL_LAST
    } state_t;

    function automatic logic [3:0] min4(input logic [3:0] x, input logic [3:0] y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/mq_byteout.sv
// Combinational MQ byte-out: carry resolution and 0xFF bit-stuffing.
// Produces the next C, B, CT and the byte leaving the coder.
module mq_byteout
    import mq_pkg::*;
(
    input  logic [C_W-1:0] c_i,
    input  logic [7:0]     b_i,
    input  logic           first_i,
    output logic [C_W-1:0] c_o,
    output logic [7:0]     b_o,
    output logic [3:0]     ct_o,
    output logic           emit_o,
    output logic [7:0]     byte_o
);

    logic [7:0] b_inc;

    assign b_inc = b_i + 8'd1;

    // Select between stuffed, plain and carry-propagated byte paths
    always_comb begin
        c_o    = c_i & MASK19;
        b_o    = c_i[26:19];
        ct_o   = 4'd8;
        byte_o = b_i;
        emit_o = !first_i;
        if (b_i == STUFF) begin
            byte_o = STUFF;
            b_o    = c_i[27:20];
            c_o    = c_i & MASK20;
            ct_o   = 4'd7;
        end else if (c_i[27]) begin
            if (b_inc == STUFF) begin
                byte_o = STUFF;
                b_o    = {1'b0, c_i[26:20]};
                c_o    = c_i & MASK20;
                ct_o   = 4'd7;
            end else begin
                byte_o = b_inc;
            end
        end
    end

endmodule

// File: rtl/mq_code_update.sv
// MQ coder C-register update: add Qe, renormalise, byte-out, flush.
// Long shifts are split across cycles at each CT boundary.
module mq_code_update
    import mq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_CU,
    input  logic        flush_CU,
    input  logic        sym_valid,
    input  logic        CSel_CU,
    input  logic [15:0] Qe_value_CU,
    input  logic [3:0]  LZ_CU,
    input  logic [15:0] AShifted_CU,
    output logic        ready_CU,
    output logic [3:0]  CT_renorm_toCU,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        flush_done
);

    state_t         state_q, state_d;
    logic [C_W-1:0] c_q, c_d;
    logic [3:0]     ct_q, ct_d;
    logic [7:0]     b_q, b_d;
    logic           first_q, first_d;
    logic [3:0]     rem_q, rem_d;
    logic           pend_q, pend_d;
    logic [7:0]     byte_q, byte_d;
    logic           bval_q, bval_d;
    logic           done_q, done_d;

    logic [C_W-1:0] sh_in, sh_c, fl_c, bo_in;
    logic [3:0]     sh_rem, sh_s, sh_ct;
    logic [C_W:0]   t_sum;
    logic [C_W-1:0] c_or, c_set;
    logic [C_W-1:0] bo_c;
    logic [7:0]     bo_b, bo_byte;
    logic [3:0]     bo_ct;
    logic           bo_emit;
    logic           do_shift, do_bo;

    // Shift datapath: new symbol operand in RUN, leftover shift in SHIFT
    always_comb begin
        sh_in  = c_q;
        sh_rem = rem_q;
        if (state_q == RUN) begin
            sh_in  = c_q + (CSel_CU ? {12'd0, Qe_value_CU} : '0);
            sh_rem = LZ_CU;
        end
        sh_s  = min4(sh_rem, ct_q);
        sh_c  = sh_in << sh_s;
        sh_ct = ct_q - sh_s;
        fl_c  = c_q << ct_q;
        t_sum = {1'b0, c_q} + {13'd0, AShifted_CU};
        c_or  = c_q | 28'h000FFFF;
        c_set = ({1'b0, c_or} >= t_sum) ? c_or - 28'h0008000 : c_or;
        bo_in = (state_q == FL_SH1 || state_q == FL_SH2) ? fl_c : sh_c;
    end

    mq_byteout u_bo (
        .c_i     (bo_in),
        .b_i     (b_q),
        .first_i (first_q),
        .c_o     (bo_c),
        .b_o     (bo_b),
        .ct_o    (bo_ct),
        .emit_o  (bo_emit),
        .byte_o  (bo_byte)
    );

    // Next-state and register updates for symbol, shift and flush paths
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        ct_d     = ct_q;
        b_d      = b_q;
        first_d  = first_q;
        rem_d    = rem_q;
        pend_d   = pend_q;
        byte_d   = byte_q;
        bval_d   = 1'b0;
        done_d   = 1'b0;
        do_shift = 1'b0;
        do_bo    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (sym_valid) begin
                    do_shift = 1'b1;
                    if (flush_CU) pend_d = 1'b1;
                end else if (flush_CU || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = FL_SET;
                end
            end
            SHIFT: do_shift = 1'b1;
            FL_SET: begin
                c_d     = c_set;
                state_d = FL_SH1;
            end
            FL_SH1: begin
                do_bo   = 1'b1;
                state_d = FL_SH2;
            end
            FL_SH2: begin
                do_bo   = 1'b1;
                state_d = FL_LAST;
            end
            FL_LAST: begin
                if (b_q != STUFF) begin
                    bval_d  = !first_q;
                    if (!first_q) byte_d = b_q;
                    first_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (do_shift) begin
            c_d     = sh_c;
            ct_d    = sh_ct;
            rem_d   = sh_rem - sh_s;
            state_d = (sh_rem == sh_s) ? RUN : SHIFT;
            do_bo   = (sh_ct == 4'd0);
        end
        if (do_bo) begin
            c_d     = bo_c;
            b_d     = bo_b;
            ct_d    = bo_ct;
            first_d = 1'b0;
            bval_d  = bo_emit;
            if (bo_emit) byte_d = bo_byte;
        end
        if (rst_CU) begin
            state_d = RUN;
            c_d     = '0;
            ct_d    = CT_INIT;
            b_d     = 8'd0;
            first_d = 1'b1;
            rem_d   = 4'd0;
            pend_d  = 1'b0;
            bval_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            c_q     <= '0;
            ct_q    <= CT_INIT;
            b_q     <= 8'd0;
            first_q <= 1'b1;
            rem_q   <= 4'd0;
            pend_q  <= 1'b0;
            byte_q  <= 8'd0;
            bval_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            ct_q    <= ct_d;
            b_q     <= b_d;
            first_q <= first_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            byte_q  <= byte_d;
            bval_q  <= bval_d;
            done_q  <= done_d;
        end
    end

    assign ready_CU       = (state_q == RUN);
    assign CT_renorm_toCU = ct_q;
    assign byte_out       = byte_q;
    assign byte_valid     = bval_q;
    assign flush_done     = done_q;

endmodule

// File: tb/tb_mq_code_update.sv
// Directed and model-based bench for the MQ code-register stage.
// Tasks run in sequence; each checks its own expected values inline.
module tb_mq_code_update;

    logic        clk = 1'b0;
    logic        rst, rst_CU, flush_CU, sym_valid, CSel_CU;
    logic [15:0] Qe_value_CU, AShifted_CU;
    logic [3:0]  LZ_CU;
    logic        ready_CU;
    logic [3:0]  CT_renorm_toCU;
    logic [7:0]  byte_out;
    logic        byte_valid, flush_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic        mon_en = 1'b0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    logic [27:0] m_c;
    logic [3:0]  m_ct;
    logic [7:0]  m_b;
    logic        m_first;

    mq_code_update dut (
        .clk            (clk),
        .rst            (rst),
        .rst_CU         (rst_CU),
        .flush_CU       (flush_CU),
        .sym_valid      (sym_valid),
        .CSel_CU        (CSel_CU),
        .Qe_value_CU    (Qe_value_CU),
        .LZ_CU          (LZ_CU),
        .AShifted_CU    (AShifted_CU),
        .ready_CU       (ready_CU),
        .CT_renorm_toCU (CT_renorm_toCU),
        .byte_out       (byte_out),
        .byte_valid     (byte_valid),
        .flush_done     (flush_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && byte_valid) got_q.push_back(byte_out);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic drive(input logic sv, input logic cs, input logic [15:0] qe,
                         input logic [3:0] lz, input logic fl, input logic [15:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_CU && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_CU) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_wait got 0 want 1");
        end
        sym_valid   = sv;
        CSel_CU     = cs;
        Qe_value_CU = qe;
        LZ_CU       = lz;
        flush_CU    = fl;
        AShifted_CU = a;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        flush_CU  = 1'b0;
    endtask

    task automatic sym(input logic cs, input logic [15:0] qe, input logic [3:0] lz);
        drive(1'b1, cs, qe, lz, 1'b0, 16'h8000);
    endtask

    task automatic pulse_init();
        @(negedge clk);
        rst_CU = 1'b1;
        @(posedge clk);
        #1;
        rst_CU = 1'b0;
    endtask

    // Bit-serial reference coder
    task automatic m_emit(input logic [7:0] v);
        if (!m_first) exp_q.push_back(v);
        m_first = 1'b0;
    endtask

    task automatic m_byteout();
        if (m_b == 8'hFF) begin
            m_emit(m_b);
            m_b  = m_c[27:20];
            m_c  = m_c & 28'hFFFFF;
            m_ct = 4'd7;
        end else if (m_c < 28'h8000000) begin
            m_emit(m_b);
            m_b  = m_c[26:19];
            m_c  = m_c & 28'h7FFFF;
            m_ct = 4'd8;
        end else begin
            m_b = m_b + 8'd1;
            if (m_b == 8'hFF) begin
                m_c[27] = 1'b0;
                m_emit(m_b);
                m_b  = m_c[27:20];
                m_c  = m_c & 28'hFFFFF;
                m_ct = 4'd7;
            end else begin
                m_emit(m_b);
                m_b  = m_c[26:19];
                m_c  = m_c & 28'h7FFFF;
                m_ct = 4'd8;
            end
        end
    endtask

    task automatic m_sym(input logic cs, input logic [15:0] qe, input logic [3:0] lz);
        if (cs) m_c = m_c + {12'd0, qe};
        for (int k = 0; k < int'(lz); k++) begin
            m_c  = m_c << 1;
            m_ct = m_ct - 4'd1;
            if (m_ct == 4'd0) m_byteout();
        end
    endtask

    task automatic m_flush(input logic [15:0] a);
        logic [28:0] t;
        t   = {1'b0, m_c} + {13'd0, a};
        m_c = m_c | 28'hFFFF;
        if ({1'b0, m_c} >= t) m_c = m_c - 28'h8000;
        m_c = m_c << m_ct;
        m_byteout();
        m_c = m_c << m_ct;
        m_byteout();
        if (m_b != 8'hFF) m_emit(m_b);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_CU = 1'b0; flush_CU = 1'b0; sym_valid = 1'b0;
        CSel_CU = 1'b0; Qe_value_CU = 16'h0; LZ_CU = 4'h0; AShifted_CU = 16'h8000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (ready_CU !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", ready_CU); end
        n_cmp++; if (CT_renorm_toCU !== 4'd12) begin n_bad++; $display("FAIL rst_ct got %0d want 12", CT_renorm_toCU); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL rst_bval got %b want 0", byte_valid); end
        n_cmp++; if (byte_out !== 8'h00) begin n_bad++; $display("FAIL rst_byte got %h want 00", byte_out); end
        n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", flush_done); end
        n_cmp++; if (dut.c_q !== 28'h0) begin n_bad++; $display("FAIL rst_c got %h want 0", dut.c_q); end
    endtask

    task automatic test_first_byte();
        pulse_init();
        sym(1'b1, 16'h5601, 4'd0);
        n_cmp++; if (dut.c_q !== 28'h5601) begin n_bad++; $display("FAIL add_c got %h want 5601", dut.c_q); end
        n_cmp++; if (CT_renorm_toCU !== 4'd12) begin n_bad++; $display("FAIL add_ct got %0d want 12", CT_renorm_toCU); end
        sym(1'b0, 16'h0, 4'd12);
        n_cmp++; if (dut.b_q !== 8'hAC) begin n_bad++; $display("FAIL first_b got %h want ac", dut.b_q); end
        n_cmp++; if (dut.c_q !== 28'h1000) begin n_bad++; $display("FAIL first_c got %h want 1000", dut.c_q); end
        n_cmp++; if (CT_renorm_toCU !== 4'd8) begin n_bad++; $display("FAIL first_ct got %0d want 8", CT_renorm_toCU); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL first_bval got %b want 0", byte_valid); end
    endtask

    task automatic test_stuff();
        repeat (8) sym(1'b1, 16'hFD00, 4'd0);
        sym(1'b0, 16'h0, 4'd8);
        n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL plain_bval got %b want 1", byte_valid); end
        n_cmp++; if (byte_out !== 8'hAC) begin n_bad++; $display("FAIL plain_byte got %h want ac", byte_out); end
        n_cmp++; if (dut.b_q !== 8'hFF) begin n_bad++; $display("FAIL plain_b got %h want ff", dut.b_q); end
        sym(1'b1, 16'h1234, 4'd8);
        n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL stuff_bval got %b want 1", byte_valid); end
        n_cmp++; if (byte_out !== 8'hFF) begin n_bad++; $display("FAIL stuff_byte got %h want ff", byte_out); end
        n_cmp++; if (CT_renorm_toCU !== 4'd7) begin n_bad++; $display("FAIL stuff_ct got %0d want 7", CT_renorm_toCU); end
        n_cmp++; if (dut.b_q !== 8'h01) begin n_bad++; $display("FAIL stuff_b got %h want 01", dut.b_q); end
        n_cmp++; if (dut.c_q !== 28'h23400) begin n_bad++; $display("FAIL stuff_c got %h want 23400", dut.c_q); end
    endtask

    task automatic test_carry();
        repeat (6) sym(1'b1, 16'hF500, 4'd0);
        sym(1'b0, 16'h0, 4'd7);
        n_cmp++; if (byte_out !== 8'h01) begin n_bad++; $display("FAIL pre7f_byte got %h want 01", byte_out); end
        n_cmp++; if (dut.b_q !== 8'h7F) begin n_bad++; $display("FAIL pre7f_b got %h want 7f", dut.b_q); end
        repeat (8) sym(1'b1, 16'hE000, 4'd0);
        sym(1'b0, 16'h0, 4'd8);
        n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL carry_bval got %b want 1", byte_valid); end
        n_cmp++; if (byte_out !== 8'h80) begin n_bad++; $display("FAIL carry_byte got %h want 80", byte_out); end
        n_cmp++; if (CT_renorm_toCU !== 4'd8) begin n_bad++; $display("FAIL carry_ct got %0d want 8", CT_renorm_toCU); end
        repeat (8) sym(1'b1, 16'hFE00, 4'd0);
        sym(1'b0, 16'h0, 4'd8);
        n_cmp++; if (dut.b_q !== 8'hFE) begin n_bad++; $display("FAIL prefe_b got %h want fe", dut.b_q); end
        repeat (16) sym(1'b1, 16'h8000, 4'd0);
        sym(1'b0, 16'h0, 4'd8);
        n_cmp++; if (byte_out !== 8'hFF) begin n_bad++; $display("FAIL carryff_byte got %h want ff", byte_out); end
        n_cmp++; if (CT_renorm_toCU !== 4'd7) begin n_bad++; $display("FAIL carryff_ct got %0d want 7", CT_renorm_toCU); end
        n_cmp++; if (dut.b_q !== 8'h00) begin n_bad++; $display("FAIL carryff_b got %h want 00", dut.b_q); end
    endtask

    task automatic test_worst_shift();
        sym(1'b0, 16'h0, 4'd6);
        n_cmp++; if (CT_renorm_toCU !== 4'd1) begin n_bad++; $display("FAIL ws_pre_ct got %0d want 1", CT_renorm_toCU); end
        sym(1'b1, 16'hABCD, 4'd15);
        n_cmp++; if (ready_CU !== 1'b0) begin n_bad++; $display("FAIL ws_rdy1 got %b want 0", ready_CU); end
        n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL ws_bval1 got %b want 1", byte_valid); end
        n_cmp++; if (CT_renorm_toCU !== 4'd8) begin n_bad++; $display("FAIL ws_ct1 got %0d want 8", CT_renorm_toCU); end
        @(posedge clk); #1;
        n_cmp++; if (ready_CU !== 1'b0) begin n_bad++; $display("FAIL ws_rdy2 got %b want 0", ready_CU); end
        n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL ws_bval2 got %b want 1", byte_valid); end
        @(posedge clk); #1;
        n_cmp++; if (ready_CU !== 1'b1) begin n_bad++; $display("FAIL ws_rdy3 got %b want 1", ready_CU); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL ws_bval3 got %b want 0", byte_valid); end
        n_cmp++; if (CT_renorm_toCU !== 4'd2) begin n_bad++; $display("FAIL ws_ct3 got %0d want 2", CT_renorm_toCU); end
        n_cmp++; if (dut.c_q !== 28'h1E68000) begin n_bad++; $display("FAIL ws_c got %h want 1e68000", dut.c_q); end
        n_cmp++; if (dut.b_q !== 8'h2A) begin n_bad++; $display("FAIL ws_b got %h want 2a", dut.b_q); end
    endtask

    task automatic test_init_mid_shift();
        sym(1'b0, 16'h0, 4'd15);
        n_cmp++; if (ready_CU !== 1'b0) begin n_bad++; $display("FAIL ms_rdy got %b want 0", ready_CU); end
        n_cmp++; if (byte_out !== 8'h2A) begin n_bad++; $display("FAIL ms_byte got %h want 2a", byte_out); end
        pulse_init();
        n_cmp++; if (ready_CU !== 1'b1) begin n_bad++; $display("FAIL ms_init_rdy got %b want 1", ready_CU); end
        n_cmp++; if (CT_renorm_toCU !== 4'd12) begin n_bad++; $display("FAIL ms_init_ct got %0d want 12", CT_renorm_toCU); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL ms_init_bval got %b want 0", byte_valid); end
        n_cmp++; if (dut.c_q !== 28'h0) begin n_bad++; $display("FAIL ms_init_c got %h want 0", dut.c_q); end
    endtask

    task automatic test_flush();
        pulse_init();
        sym(1'b1, 16'h5601, 4'd0);
        drive(1'b0, 1'b0, 16'h0, 4'd0, 1'b1, 16'h8000);
        n_cmp++; if (ready_CU !== 1'b0) begin n_bad++; $display("FAIL fl_rdy0 got %b want 0", ready_CU); end
        @(posedge clk); #1;
        n_cmp++; if (dut.c_q !== 28'h7FFF) begin n_bad++; $display("FAIL fl_set_c got %h want 7fff", dut.c_q); end
        @(posedge clk); #1;
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL fl_sh1_bval got %b want 0", byte_valid); end
        @(posedge clk); #1;
        n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL fl_sh2_bval got %b want 1", byte_valid); end
        n_cmp++; if (byte_out !== 8'hFF) begin n_bad++; $display("FAIL fl_sh2_byte got %h want ff", byte_out); end
        n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL fl_sh2_done got %b want 0", flush_done); end
        @(posedge clk); #1;
        n_cmp++; if (byte_out !== 8'h7F) begin n_bad++; $display("FAIL fl_last_byte got %h want 7f", byte_out); end
        n_cmp++; if (flush_done !== 1'b1) begin n_bad++; $display("FAIL fl_last_done got %b want 1", flush_done); end
        n_cmp++; if (ready_CU !== 1'b1) begin n_bad++; $display("FAIL fl_last_rdy got %b want 1", ready_CU); end
        @(posedge clk); #1;
        n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL fl_after_done got %b want 0", flush_done); end
    endtask

    task automatic test_back_to_back();
        int k;
        pulse_init();
        drive(1'b1, 1'b1, 16'h5601, 4'd0, 1'b1, 16'h8000);
        n_cmp++; if (ready_CU !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy got %b want 1", ready_CU); end
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (flush_done) break;
        end
        n_cmp++; if (k != 5) begin n_bad++; $display("FAIL b2b_latency got %0d want 5", k); end
        n_cmp++; if (byte_out !== 8'h7F) begin n_bad++; $display("FAIL b2b_byte got %h want 7f", byte_out); end
    endtask

    task automatic test_random_stream();
        logic        cs;
        logic [15:0] qe, a;
        logic [3:0]  lz;
        int          k, n;
        pulse_init();
        got_q.delete();
        exp_q.delete();
        m_c = '0; m_ct = 4'd12; m_b = 8'h00; m_first = 1'b1;
        mon_en = 1'b1;
        a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        for (int i = 0; i < 64; i++) begin
            cs = 1'($urandom_range(0, 1));
            qe = 16'($urandom_range(0, 16'hFFFF));
            lz = 4'($urandom_range(0, 15));
            m_sym(cs, qe, lz);
            drive(1'b1, cs, qe, lz, (i == 63), a);
        end
        m_flush(a);
        k = 0;
        while (k < 40 && !flush_done) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++; if (flush_done !== 1'b1) begin n_bad++; $display("FAIL rnd_done got %b want 1", flush_done); end
        @(negedge clk); #1;
        mon_en = 1'b0;
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size()); end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rnd_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++; if (CT_renorm_toCU !== m_ct) begin n_bad++; $display("FAIL rnd_ct got %0d want %0d", CT_renorm_toCU, m_ct); end
    endtask

    initial begin
        test_reset();
        test_first_byte();
        test_stuff();
        test_carry();
        test_worst_shift();
        test_init_mid_shift();
        test_flush();
        test_back_to_back();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
